// File: rtl/uart_rx_param.sv
// Parameterised UART receiver: 2-flop synchronised input, mid-bit sampling,
// optional parity, 1 or 2 stop bits, and a valid/ready output register with overrun detection.
module uart_rx_param #(
  parameter int DATA_BITS    = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_EN    = 1,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx_in,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [CW-1:0] CNT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_HALF  = CW'(CLKS_PER_BIT / 2);
  localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);
  localparam logic          ODD       = (PARITY_ODD != 0);
  localparam logic          HAS_PAR   = (PARITY_EN != 0);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t                 state_reg, state_next;
  logic [1:0]             sync_reg;
  logic [1:0]             fill_reg;
  logic                   prev_reg;
  logic [CW-1:0]          cnt_reg;
  logic [BW-1:0]          bit_reg;
  logic [DATA_BITS-1:0]   shift_reg;
  logic                   perr_reg;
  logic                   ferr_reg;
  logic                   rx_s;
  logic                   tick;
  logic                   fall;
  logic                   frame_done;
  logic                   par_mismatch;

  assign rx_s         = sync_reg[1];
  assign tick         = (cnt_reg == CNT_LAST);
  assign fall         = prev_reg & ~rx_s;
  assign par_mismatch = HAS_PAR & (rx_s != ((^shift_reg) ^ ODD));
  assign busy         = (state_reg != IDLE);

  // prev_reg only goes high once the synchroniser holds a genuine line sample,
  // so a line that is low out of reset (or held in break) never looks like a start edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_reg <= 2'b11;
      fill_reg <= 2'b00;
      prev_reg <= 1'b0;
    end else begin
      sync_reg <= {sync_reg[0], rx_in};
      fill_reg <= {fill_reg[0], 1'b1};
      prev_reg <= fill_reg[1] & rx_s;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    frame_done = 1'b0;
    case (state_reg)
      IDLE:   if (fall) state_next = START;
      START:  if (cnt_reg == CNT_HALF) state_next = rx_s ? IDLE : DATA;
      DATA:   if (tick && bit_reg == DATA_LAST) state_next = HAS_PAR ? PARITY : STOP;
      PARITY: if (tick) state_next = STOP;
      STOP: begin
        if (tick && bit_reg == STOP_LAST) begin
          state_next = IDLE;
          frame_done = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg   <= '0;
      bit_reg   <= '0;
      shift_reg <= '0;
      perr_reg  <= 1'b0;
      ferr_reg  <= 1'b0;
    end else begin
      if (state_next != state_reg) begin
        cnt_reg <= '0;
        bit_reg <= '0;
      end else if (state_reg != IDLE) begin
        cnt_reg <= tick ? '0 : cnt_reg + CW'(1);
        if (tick && (state_reg == DATA || state_reg == STOP))
          bit_reg <= bit_reg + BW'(1);
      end

      if (state_reg == START) begin
        perr_reg <= 1'b0;
        ferr_reg <= 1'b0;
      end
      if (state_reg == DATA && tick)
        shift_reg <= {rx_s, shift_reg[DATA_BITS-1:1]};
      if (state_reg == PARITY && tick)
        perr_reg <= par_mismatch;
      if (state_reg == STOP && tick && !rx_s)
        ferr_reg <= 1'b1;
    end
  end

  // A completed frame is dropped only when the held one is not being consumed this cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (frame_done) begin
        if (!rx_valid || rx_ready) begin
          rx_data    <= shift_reg;
          parity_err <= perr_reg;
          frame_err  <= ferr_reg | ~rx_s;
          rx_valid   <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_param.sv
// Bench for uart_rx_param: three parameterisations driven with table and random
// frames, checked against a frame-level reference model.
module tb_uart_rx_param;
  localparam int CPB = 16;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] rx_line;
  logic [2:0] rdy;
  logic [7:0] d0, d1;
  logic [6:0] d2;
  logic v0, v1, v2, p0, p1, p2, f0, f1, f2, o0, o1, o2, b0, b1, b2;

  always #5 clk = ~clk;

  uart_rx_param u_def (
    .clk(clk), .rst_n(rst_n), .rx_in(rx_line[0]), .rx_data(d0), .rx_valid(v0),
    .rx_ready(rdy[0]), .parity_err(p0), .frame_err(f0), .overrun(o0), .busy(b0)
  );

  uart_rx_param #(.PARITY_ODD(1)) u_odd (
    .clk(clk), .rst_n(rst_n), .rx_in(rx_line[1]), .rx_data(d1), .rx_valid(v1),
    .rx_ready(rdy[1]), .parity_err(p1), .frame_err(f1), .overrun(o1), .busy(b1)
  );

  uart_rx_param #(.DATA_BITS(7), .STOP_BITS(2)) u_s2 (
    .clk(clk), .rst_n(rst_n), .rx_in(rx_line[2]), .rx_data(d2), .rx_valid(v2),
    .rx_ready(rdy[2]), .parity_err(p2), .frame_err(f2), .overrun(o2), .busy(b2)
  );

  int applied = 0;
  int miscompares = 0;
  int q0[$];
  int q1[$];
  int q2[$];
  int ov_cnt[3];
  int vh_cnt[3];

  function automatic int pack(input int d, input int p, input int f);
    return d | (p << 9) | (f << 10);
  endfunction

  // Reference: what the receiver must report for a given line frame.
  function automatic int model(input int nbits, input int data, input bit odd,
                               input bit pbit, input int nstop, input bit s0, input bit s1);
    int d, want_p, perr, ferr;
    d      = data & ((1 << nbits) - 1);
    want_p = ($countones(d) % 2) ^ int'(odd);
    perr   = (int'(pbit) != want_p) ? 1 : 0;
    ferr   = (!s0 || (nstop == 2 && !s1)) ? 1 : 0;
    return pack(d, perr, ferr);
  endfunction

  always @(negedge clk) begin
    if (v0 && rdy[0]) q0.push_back(pack(int'(d0), int'(p0), int'(f0)));
    if (v1 && rdy[1]) q1.push_back(pack(int'(d1), int'(p1), int'(f1)));
    if (v2 && rdy[2]) q2.push_back(pack(int'(d2), int'(p2), int'(f2)));
    if (o0) ov_cnt[0]++;
    if (o1) ov_cnt[1]++;
    if (o2) ov_cnt[2]++;
    if (v0) vh_cnt[0]++;
    if (v1) vh_cnt[1]++;
    if (v2) vh_cnt[2]++;
  end

  task automatic chk(input string name, input int act, input int exp);
    applied++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input int w, input int nbits, input logic [8:0] data,
                      input bit pbit, input int nstop, input bit s0, input bit s1);
    rx_line[w] = 1'b1; cyc(8);
    rx_line[w] = 1'b0; cyc(CPB);
    for (int i = 0; i < nbits; i++) begin
      rx_line[w] = data[i]; cyc(CPB);
    end
    rx_line[w] = pbit; cyc(CPB);
    rx_line[w] = s0; cyc(CPB);
    if (nstop == 2) begin
      rx_line[w] = s1; cyc(CPB);
    end
    rx_line[w] = 1'b1; cyc(4);
  endtask

  task automatic expect_frame(input int w, input string tag, input int exp);
    int n, got;
    got = -1;
    case (w)
      0: n = q0.size();
      1: n = q1.size();
      default: n = q2.size();
    endcase
    chk({tag, "_frames"}, n, 1);
    if (n > 0) begin
      case (w)
        0: begin got = q0.pop_front(); q0.delete(); end
        1: begin got = q1.pop_front(); q1.delete(); end
        default: begin got = q2.pop_front(); q2.delete(); end
      endcase
      chk({tag, "_data"}, got & 'h1ff, exp & 'h1ff);
      chk({tag, "_perr"}, (got >> 9) & 1, (exp >> 9) & 1);
      chk({tag, "_ferr"}, (got >> 10) & 1, (exp >> 10) & 1);
    end
    $display("frame %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  typedef struct {
    logic [7:0] data;
    logic       pbit;
    logic       stop;
    logic [7:0] exp_data;
    logic       exp_perr;
    logic       exp_ferr;
  } vec_t;

  vec_t tbl[7];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int vb, ob, exp;
    logic [7:0] rd;
    logic rp, rs;

    tbl[0] = '{8'hA5, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0};
    tbl[1] = '{8'hA5, 1'b1, 1'b1, 8'hA5, 1'b1, 1'b0};
    tbl[2] = '{8'h3C, 1'b0, 1'b1, 8'h3C, 1'b0, 1'b0};
    tbl[3] = '{8'h01, 1'b1, 1'b1, 8'h01, 1'b0, 1'b0};
    tbl[4] = '{8'h01, 1'b0, 1'b1, 8'h01, 1'b1, 1'b0};
    tbl[5] = '{8'hFF, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b1};
    tbl[6] = '{8'h80, 1'b1, 1'b1, 8'h80, 1'b0, 1'b0};

    rst_n = 1'b0; rx_line = 3'b111; rdy = 3'b111;
    cyc(3);
    chk("rst_valid0", int'(v0), 0);
    chk("rst_data0", int'(d0), 0);
    chk("rst_perr0", int'(p0), 0);
    chk("rst_ferr0", int'(f0), 0);
    chk("rst_ovr0", int'(o0), 0);
    chk("rst_busy0", int'(b0), 0);
    chk("rst_valid2", int'(v2), 0);
    chk("rst_busy2", int'(b2), 0);
    rst_n = 1'b1;
    cyc(4);

    for (int i = 0; i < 7; i++) begin
      vb = vh_cnt[0];
      send(0, 8, {1'b0, tbl[i].data}, tbl[i].pbit, 1, tbl[i].stop, 1'b1);
      expect_frame(0, $sformatf("tbl%0d", i),
                   pack(int'(tbl[i].exp_data), int'(tbl[i].exp_perr), int'(tbl[i].exp_ferr)));
      chk($sformatf("tbl%0d_vpulse", i), vh_cnt[0] - vb, 1);
    end

    send(1, 8, 9'h0A5, 1'b1, 1, 1'b1, 1'b1);
    expect_frame(1, "odd_p1", pack('hA5, 0, 0));
    send(1, 8, 9'h0A5, 1'b0, 1, 1'b1, 1'b1);
    expect_frame(1, "odd_p0", pack('hA5, 1, 0));

    send(2, 7, 9'h055, 1'b0, 2, 1'b1, 1'b0);
    expect_frame(2, "s2_stop2low", pack('h55, 0, 1));
    send(2, 7, 9'h07F, 1'b1, 2, 1'b1, 1'b1);
    expect_frame(2, "s2_clean", pack('h7F, 0, 0));

    vb = vh_cnt[0]; ob = ov_cnt[0];
    rx_line[0] = 1'b0; cyc(5);
    rx_line[0] = 1'b1; cyc(40);
    chk("glitch_busy", int'(b0), 0);
    chk("glitch_valid_cycles", vh_cnt[0] - vb, 0);
    chk("glitch_frames", q0.size(), 0);
    chk("glitch_ovr", ov_cnt[0] - ob, 0);
    $display("glitch: busy=%0d valid_cycles=%0d", b0, vh_cnt[0] - vb);

    for (int i = 0; i < 20; i++) begin
      rd = 8'($urandom_range(0, 255));
      rp = 1'($urandom_range(0, 1));
      rs = ($urandom_range(0, 3) != 0);
      exp = model(8, int'(rd), 1'b0, rp, 1, rs, 1'b1);
      send(0, 8, {1'b0, rd}, rp, 1, rs, 1'b1);
      expect_frame(0, $sformatf("rnd%0d", i), exp);
    end

    rdy[0] = 1'b0;
    ob = ov_cnt[0];
    send(0, 8, 9'h011, 1'b0, 1, 1'b1, 1'b1);
    send(0, 8, 9'h022, 1'b0, 1, 1'b1, 1'b1);
    chk("ovr_valid_held", int'(v0), 1);
    chk("ovr_data_held", int'(d0), 'h11);
    chk("ovr_pulses", ov_cnt[0] - ob, 1);
    chk("ovr_no_handshake", q0.size(), 0);
    rdy[0] = 1'b1; cyc(2);
    expect_frame(0, "ovr_consume", model(8, 'h11, 1'b0, 1'b0, 1, 1'b1, 1'b1));
    chk("ovr_valid_drop", int'(v0), 0);

    rdy[0] = 1'b0;
    send(0, 8, 9'h05A, 1'b0, 1, 1'b1, 1'b1);
    chk("hold_valid", int'(v0), 1);
    chk("hold_data", int'(d0), 'h5A);
    rx_line[0] = 1'b1; cyc(8);
    rx_line[0] = 1'b0; cyc(CPB);
    rx_line[0] = 1'b0; cyc(CPB);
    rx_line[0] = 1'b0; cyc(CPB);
    rx_line[0] = 1'b1; cyc(CPB);
    rx_line[0] = 1'b1; cyc(CPB / 2);
    chk("mid_busy", int'(b0), 1);
    #3 rst_n = 1'b0;
    #1;
    chk("async_valid", int'(v0), 0);
    chk("async_data", int'(d0), 0);
    chk("async_perr", int'(p0), 0);
    chk("async_ferr", int'(f0), 0);
    chk("async_ovr", int'(o0), 0);
    chk("async_busy", int'(b0), 0);
    rx_line[0] = 1'b0;
    cyc(3);
    rst_n = 1'b1;
    cyc(40);
    chk("low_after_rst_busy", int'(b0), 0);
    chk("low_after_rst_valid", int'(v0), 0);
    rx_line[0] = 1'b1; rdy[0] = 1'b1;
    q0.delete();
    send(0, 8, 9'h03C, 1'b0, 1, 1'b1, 1'b1);
    expect_frame(0, "post_rst", model(8, 'h3C, 1'b0, 1'b0, 1, 1'b1, 1'b1));

    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

endmodule
